// File: rtl/pe_array_output_collector.sv
// PE array output collector: ping-pong capture of PE vectors, lane-serial memory writes.
// Optional running write checksum under PE_COLLECT_CHECKSUM_EN.
module pe_array_output_collector #(
    parameter int N_PE        = 8,
    parameter int WID_PE_BITS = 16,
    parameter int ADDR_W      = 10,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [ADDR_W-1:0]           cfg_base_addr,
    input  logic [CNT_W-1:0]            cfg_num_vec,
    input  logic                        pe_valid,
    output logic                        pe_ready,
    input  logic [N_PE*WID_PE_BITS-1:0] pe_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [WID_PE_BITS-1:0]      wr_data,
    input  logic                        wr_ready,
    output logic                        busy,
    output logic                        done,
    output logic [WID_PE_BITS-1:0]      checksum
);

    localparam int LW = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(N_PE - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]                  state, n_state;
    logic [N_PE*WID_PE_BITS-1:0] ent [2];
    logic [1:0]                  vld, n_vld;
    logic                        rd_ptr, n_rd, wr_ptr;
    logic [LW-1:0]               lane, n_lane;
    logic [CNT_W-1:0]            acc_cnt, n_acc, num_r, n_num;
    logic                        accept, hs, start_ok;
    logic [N_PE*WID_PE_BITS-1:0] src;
    logic [WID_PE_BITS-1:0]      n_word;

    always_comb begin
        accept   = pe_valid && pe_ready;
        hs       = wr_en && wr_ready;
        start_ok = (state == IDLE) && cfg_start;
        n_vld    = vld;
        n_rd     = rd_ptr;
        n_lane   = lane;
        if (hs) begin
            if (lane == LAST_LANE) begin
                n_vld[rd_ptr] = 1'b0;
                n_rd          = ~rd_ptr;
                n_lane        = '0;
            end else begin
                n_lane = lane + LW'(1);
            end
        end
        if (accept) n_vld[wr_ptr] = 1'b1;
        n_num = start_ok ? cfg_num_vec : num_r;
        n_acc = start_ok ? '0 : acc_cnt + CNT_W'(accept);
        n_state = state;
        unique case (state)
            IDLE:    if (cfg_start) n_state = (cfg_num_vec == '0) ? FINISH : RUN;
            RUN:     if (n_acc == n_num && n_vld == 2'b00) n_state = FINISH;
            FINISH:  n_state = IDLE;
            default: n_state = IDLE;
        endcase
        // A vector accepted into an empty buffer is presented straight from the bus
        src    = (accept && wr_ptr == n_rd) ? pe_data : ent[n_rd];
        n_word = src[n_lane*WID_PE_BITS +: WID_PE_BITS];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ent[0]   <= '0;
            ent[1]   <= '0;
            vld      <= 2'b00;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            lane     <= '0;
            acc_cnt  <= '0;
            num_r    <= '0;
            pe_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
        end else begin
            state   <= n_state;
            vld     <= n_vld;
            rd_ptr  <= n_rd;
            lane    <= n_lane;
            acc_cnt <= n_acc;
            num_r   <= n_num;
            if (accept) begin
                ent[wr_ptr] <= pe_data;
                wr_ptr      <= ~wr_ptr;
            end
            wr_en <= n_vld[n_rd];
            if (n_vld[n_rd]) wr_data <= n_word;
            if (start_ok) wr_addr <= cfg_base_addr;
            else if (hs)  wr_addr <= wr_addr + ADDR_W'(1);
            pe_ready <= (n_state == RUN) && (n_vld != 2'b11) && (n_acc < n_num);
            done     <= (n_state == FINISH);
        end
    end

    assign busy = (state != IDLE);

`ifdef PE_COLLECT_CHECKSUM_EN
    logic [WID_PE_BITS-1:0] sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          sum <= '0;
        else if (start_ok) sum <= '0;
        else if (hs)       sum <= sum + wr_data;
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_pe_array_output_collector.sv
// Directed bench for pe_array_output_collector with a write scoreboard.
// Expected checksum follows PE_COLLECT_CHECKSUM_EN.
module tb_pe_array_output_collector;

    localparam int N_PE = 8;
    localparam int W    = 16;
    localparam int AW   = 10;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_start = 1'b0;
    logic [AW-1:0]   cfg_base_addr = '0;
    logic [CW-1:0]   cfg_num_vec = '0;
    logic            pe_valid = 1'b0;
    logic            pe_ready;
    logic [N_PE*W-1:0] pe_data = '0;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic            wr_ready = 1'b1;
    logic            busy;
    logic            done;
    logic [W-1:0]    checksum;

    pe_array_output_collector #(
        .N_PE(N_PE), .WID_PE_BITS(W), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_num_vec(cfg_num_vec),
        .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_wr, n_acc, n_done, first_wr, last_wr, first_acc;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_sum;
    logic [AW+W-1:0] sb [$];
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push expected words on accept, pop/compare on write handshake
    logic          prev_stall = 1'b0;
    logic [AW-1:0] pa;
    logic [W-1:0]  pd;
    always @(negedge clk) begin : mon
        logic [W-1:0]    w;
        logic [AW+W-1:0] e;
        if (rst) begin
            if (pe_valid && pe_ready) begin
                n_acc++;
                if (first_acc < 0) first_acc = cyc;
                for (int i = 0; i < N_PE; i++) begin
                    w = pe_data[i*W +: W];
                    sb.push_back({exp_addr, w});
                    exp_sum  = exp_sum + w;
                    exp_addr = exp_addr + 1'b1;
                end
            end
            if (prev_stall) begin
                chk("stall_en", 32'(wr_en), 32'd1);
                chk("stall_addr", 32'(wr_addr), 32'(pa));
                chk("stall_data", 32'(wr_data), 32'(pd));
            end
            if (wr_en && wr_ready) begin
                chk("wr_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e[AW+W-1:W]));
                    chk("wr_data", 32'(wr_data), 32'(e[W-1:0]));
                end
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (done) n_done++;
            prev_stall = wr_en && !wr_ready;
            pa = wr_addr;
            pd = wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_PE*W-1:0] mkvec(input int tag);
        logic [N_PE*W-1:0] v;
        for (int i = 0; i < N_PE; i++) v[i*W +: W] = W'(tag * 16 + i + 1);
        return v;
    endfunction

    function automatic logic [W-1:0] csum(input logic [W-1:0] s);
`ifdef PE_COLLECT_CHECKSUM_EN
        return s;
`else
        return (s & '0);
`endif
    endfunction

    task automatic clear_stats();
        n_wr = 0; n_acc = 0; n_done = 0;
        first_wr = -1; last_wr = -1; first_acc = -1;
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [CW-1:0] num);
        clear_stats();
        exp_addr      = base;
        exp_sum       = '0;
        cfg_base_addr = base;
        cfg_num_vec   = num;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_vec(input logic [N_PE*W-1:0] v);
        logic r;
        pe_data  = v;
        pe_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r = pe_ready;
            tick();
            if (r) begin
                pe_valid = 1'b0;
                return;
            end
        end
        pe_valid = 1'b0;
        chk("accept_timeout", 32'(pe_ready), 32'd1);
    endtask

    task automatic wait_done(input int max, input bit tog, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            if (tog) wr_ready = pat[i % 4];
            tick();
            if (done) begin
                lat = i + 1;
                wr_ready = 1'b1;
                return;
            end
        end
        wr_ready = 1'b1;
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat, idx;
        logic r;
        clear_stats();
        exp_addr = '0;
        exp_sum  = '0;

        // Reset state
        tick(); tick();
        chk("rst_pe_ready", 32'(pe_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        rst = 1'b1;

        // Valid while idle is not accepted
        pe_valid = 1'b1;
        pe_data  = mkvec(9);
        tick(); tick(); tick();
        chk("idle_ready", 32'(pe_ready), 32'd0);
        chk("idle_acc", 32'(n_acc), 32'd0);
        pe_valid = 1'b0;

        // Single vector 1..8 at 0x010
        start(10'h010, 16'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_vec(mkvec(0));
        chk("t1_ready_after", 32'(pe_ready), 32'd0);
        wait_done(100, 1'b0, lat);
        chk("t1_nwr", 32'(n_wr), 32'd8);
        chk("t1_contig", 32'(last_wr - first_wr + 1), 32'd8);
        chk("t1_latency", 32'(first_wr - first_acc), 32'd1);
        chk("t1_done_after_wr", 32'(cyc - last_wr), 32'd1);
        chk("t1_checksum", 32'(checksum), 32'(csum(16'd36)));
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_ck_hold", 32'(checksum), 32'(csum(16'd36)));

        // Four vectors, valid held high
        start(10'h100, 16'd4);
        idx = 0;
        pe_valid = 1'b1;
        pe_data  = mkvec(1);
        for (int i = 0; i < 200 && idx < 4; i++) begin
            r = pe_ready;
            tick();
            if (r) begin
                idx++;
                pe_data = mkvec(1 + idx);
            end
        end
        pe_valid = 1'b0;
        chk("t2_accepts", 32'(idx), 32'd4);
        wait_done(200, 1'b0, lat);
        chk("t2_nwr", 32'(n_wr), 32'd32);
        chk("t2_contig", 32'(last_wr - first_wr + 1), 32'd32);
        chk("t2_nacc", 32'(n_acc), 32'd4);
        chk("t2_checksum", 32'(checksum), 32'(csum(exp_sum)));
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Backpressure 1,0,0,1
        start(10'h200, 16'd1);
        send_vec(mkvec(7));
        wait_done(200, 1'b1, lat);
        chk("t3_nwr", 32'(n_wr), 32'd8);
        chk("t3_addr", 32'(wr_addr), 32'h208);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Address wrap
        start(10'h3FC, 16'd1);
        send_vec(mkvec(3));
        wait_done(100, 1'b0, lat);
        chk("t4_nwr", 32'(n_wr), 32'd8);
        chk("t4_addr_wrap", 32'(wr_addr), 32'h004);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Zero-length pass
        start(10'h055, 16'd0);
        lat = done ? 1 : -1;
        if (!done) wait_done(2, 1'b0, lat);
        chk("t5_done_quick", 32'(lat >= 1 && lat <= 2), 32'd1);
        tick();
        chk("t5_done_pulse", 32'(done), 32'd0);
        chk("t5_nwr", 32'(n_wr), 32'd0);
        chk("t5_ndone", 32'(n_done), 32'd1);
        tick();

        // cfg_start during busy is ignored
        start(10'h040, 16'd3);
        send_vec(mkvec(4));
        cfg_base_addr = 10'h300;
        cfg_num_vec   = 16'd1;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t5b_busy", 32'(busy), 32'd1);
        send_vec(mkvec(5));
        send_vec(mkvec(6));
        wait_done(200, 1'b0, lat);
        chk("t5b_nwr", 32'(n_wr), 32'd24);
        chk("t5b_addr", 32'(wr_addr), 32'h058);
        chk("t5b_checksum", 32'(checksum), 32'(csum(exp_sum)));
        chk("t5b_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Reset mid-vector
        start(10'h080, 16'd1);
        send_vec(mkvec(8));
        for (int i = 0; i < 50 && n_wr < 3; i++) tick();
        chk("t6_pre_nwr", 32'(n_wr), 32'd3);
        rst = 1'b0;
        #1;
        chk("t6_wr_en", 32'(wr_en), 32'd0);
        chk("t6_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_ready", 32'(pe_ready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_checksum", 32'(checksum), 32'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_no_done", 32'(n_done), 32'd0);
        start(10'h0C0, 16'd1);
        send_vec(mkvec(10));
        wait_done(100, 1'b0, lat);
        chk("t6_nwr", 32'(n_wr), 32'd8);
        chk("t6_addr", 32'(wr_addr), 32'h0C8);
        chk("t6_checksum2", 32'(checksum), 32'(csum(exp_sum)));
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
